cache_mem_arbiter: RTL

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_pkg.sv | 19 +
 rtl/inflight_ctr.sv | 48 ++++
 rtl/cache_mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int MEM_LAT_DEF = 4;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_FILL = 2'd1,
        ST_D_FILL = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/inflight_ctr.sv
// Up/down counter of outstanding memory reads; a decrement at zero is dropped.
module inflight_ctr
    import cache_pkg::*;
#(
    parameter int MAX = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic nxt_zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_eff;

    assign dec_eff = dec_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_eff) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!inc_i && dec_eff) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // More reads in flight than the memory latency allows means the requester misbehaved.
    always_ff @(posedge clk) begin
        if (!rst && inc_i && !dec_eff) begin
            assert (cnt_q < CNT_W'(MAX));
        end
    end

    assign zero_o     = (cnt_q == '0);
    assign nxt_zero_o = (cnt_d == '0);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one memory port between I-cache fills, D-cache fills and D-side write-through stores.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_rd,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic              d_wr_stall
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_owner_q;
    logic       last_owner_d;

    logic              rd_issue;
    logic              wr_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic              owner_i;
    logic              owner_d;
    logic              cnt_zero;
    logic              cnt_nxt_zero;
    logic              valid_route;

    inflight_ctr #(
        .MAX (MEM_LAT)
    ) u_inflight_ctr (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (rd_issue),
        .dec_i      (mem_data_valid),
        .zero_o     (cnt_zero),
        .nxt_zero_o (cnt_nxt_zero)
    );

    // A read is issued only while its requester still owns the port and holds req.
    assign rd_issue = !rst && (((state_q == ST_I_FILL) && i_req && i_rd) ||
                               ((state_q == ST_D_FILL) && d_req && d_rd));
    assign rd_addr  = (state_q == ST_I_FILL) ? i_addr : d_addr;
    assign wr_issue = !rst && (state_q == ST_IDLE) && d_wr;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (d_wr) begin
                    state_d = ST_IDLE;
                end else if (i_req && d_req) begin
                    state_d = (last_owner_q == OWNER_D) ? ST_I_FILL : ST_D_FILL;
                end else if (i_req) begin
                    state_d = ST_I_FILL;
                end else if (d_req) begin
                    state_d = ST_D_FILL;
                end
            end
            ST_I_FILL: begin
                if (!i_req) begin
                    last_owner_d = OWNER_I;
                    state_d      = cnt_nxt_zero ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_D_FILL: begin
                if (!d_req) begin
                    last_owner_d = OWNER_D;
                    state_d      = cnt_nxt_zero ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_nxt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_D;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // In DRAIN the owner is whoever just left the fill state.
    assign owner_i = (state_q == ST_I_FILL) || ((state_q == ST_DRAIN) && (last_owner_q == OWNER_I));
    assign owner_d = (state_q == ST_D_FILL) || ((state_q == ST_DRAIN) && (last_owner_q == OWNER_D));

    assign valid_route  = !rst && mem_data_valid && !cnt_zero;
    assign i_grant      = !rst && owner_i;
    assign d_grant      = !rst && owner_d;
    assign i_data_valid = valid_route && owner_i;
    assign d_data_valid = valid_route && owner_d;
    assign fill_data    = mem_rdata;

    assign d_wr_stall = !rst && d_wr && (state_q != ST_IDLE);
    assign mem_en     = rd_issue || wr_issue;
    assign mem_wr     = wr_issue;
    assign mem_addr   = wr_issue ? d_wr_addr : (rd_issue ? rd_addr : '0);
    assign mem_wdata  = wr_issue ? d_wr_data : '0;

endmodule
